// File: rtl/uart_host_rx.sv
// uart_host_rx: 8N1 serial receiver with PIC-style SPBRG/BRGH timing, byte FIFO and sticky errors
module uart_host_rx #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         brgh,
   input  logic [7:0]                   spbrg,
   input  logic                         rxd,
   input  logic                         rd_en,
   output logic [7:0]                   rd_data,
   output logic                         rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]  count,
   output logic                         framing_err,
   output logic                         overrun_err,
   input  logic                         err_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_nx;
   logic rxd_m, rxd_s, rxd_p;
   logic [9:0] presc, lim;
   logic [3:0] tick;
   logic [2:0] bit_cnt;
   logic [7:0] sh;
   logic s7, s8;
   logic start_edge, run, decide, vote, shift, push, ferr_set, ovr_set;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic full, do_push, do_pop;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {rxd_m, rxd_s, rxd_p} <= 3'b111;
      else {rxd_m, rxd_s, rxd_p} <= {rxd, rxd_m, rxd_s};

   // prescaler limit is (spbrg+1)-1 or 4*(spbrg+1)-1 clocks per tick
   assign lim        = brgh ? {2'b00, spbrg} : {spbrg, 2'b11};
   assign start_edge = en && !rxd_s && rxd_p && state == IDLE;
   assign run        = en && (state != IDLE || start_edge);
   assign decide     = state != IDLE && tick == 4'd9 && presc == '0;
   assign vote       = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         presc <= '0;
         tick  <= '0;
      end else if (!run) begin
         presc <= '0;
         tick  <= '0;
      end else if (presc >= lim) begin
         presc <= '0;
         tick  <= tick + 4'd1;
      end else presc <= presc + 10'd1;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s7 <= 1'b1;
         s8 <= 1'b1;
      end else if (presc == '0) begin
         s7 <= tick == 4'd7 ? rxd_s : s7;
         s8 <= tick == 4'd8 ? rxd_s : s8;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_edge ? START : IDLE;
         START:   state_nx = decide ? (vote ? IDLE : DATA) : START;
         DATA:    state_nx = decide && bit_cnt == 3'd7 ? STOP : DATA;
         default: state_nx = decide ? IDLE : STOP;
      endcase
      if (!en) state_nx = IDLE;
   end

   always_comb begin
      shift    = en && state == DATA && decide;
      push     = en && state == STOP && decide && vote;
      ferr_set = en && state == STOP && decide && !vote;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bit_cnt <= '0;
         sh      <= '0;
      end else begin
         bit_cnt <= state != DATA ? 3'd0 : bit_cnt + {2'b00, shift};
         sh      <= shift ? {vote, sh[7:1]} : sh;
      end

   // a pop frees a slot in the same cycle, so push at full succeeds alongside rd_en
   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign do_pop  = rd_en && count != '0;
   assign do_push = push && (!full || do_pop);
   assign ovr_set = push && full && !do_pop;

   always_ff @(posedge clk)
      if (do_push) mem[wp] <= sh;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp          <= '0;
         rp          <= '0;
         count       <= '0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         wp          <= wp + AW'(do_push);
         rp          <= rp + AW'(do_pop);
         count       <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
         framing_err <= ferr_set | (framing_err & ~err_clr);
         overrun_err <= ovr_set | (overrun_err & ~err_clr);
      end

   assign rd_valid = count != '0;
   assign rd_data  = rd_valid ? mem[rp] : 8'h00;
endmodule

// File: tb/tb_uart_host_rx.sv
// tb_uart_host_rx: scoreboard bench driving 8N1 frames onto rxd and checking FIFO output, latency and errors
module tb_uart_host_rx;
   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, brgh = 1'b1, rxd = 1'b1;
   logic       rd_en = 1'b0, err_clr = 1'b0;
   logic [7:0] spbrg = 8'd0;
   logic [7:0] rd_data;
   logic       rd_valid, framing_err, overrun_err;
   logic [2:0] count;
   int         cyc = 0, vecs = 0, errs = 0, t0;
   logic [7:0] exp_q[$];

   uart_host_rx #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .brgh(brgh), .spbrg(spbrg), .rxd(rxd),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
      .framing_err(framing_err), .overrun_err(overrun_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         rxd = f[i];
         repeat (bc) @(posedge clk);
         #1;
      end
      rxd = 1'b1;
   endtask

   task automatic sb_push(input logic [7:0] d);
      if (exp_q.size() < 4) exp_q.push_back(d);
   endtask

   task automatic pop_chk();
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         check("sb_underflow_valid", 32'(rd_valid), 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check("pop_valid", 32'(rd_valid), 32'd1);
      check("pop_data", 32'(rd_data), 32'(e));
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_data", 32'(rd_data), 32'd0);
      check("rst_ferr", 32'(framing_err), 32'd0);
      check("rst_oerr", 32'(overrun_err), 32'd0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("idle_count", 32'(count), 32'd0);

      // latency from pin start edge at 16 clks/bit
      fork
         send_frame(8'hCA, 1'b1, 16);
         begin
            @(negedge rxd);
            t0 = cyc;
            for (int i = 0; i < 400 && !rd_valid; i++) begin
               @(posedge clk); #1;
            end
            check("latency", 32'(cyc - t0), 32'd156);
         end
      join
      sb_push(8'hCA);
      pop_chk();
      check("after_pop_count", 32'(count), 32'd0);

      // slow rate: 64*(2+1) = 192 clks/bit
      brgh = 1'b0;
      spbrg = 8'd2;
      send_frame(8'h55, 1'b1, 192);
      sb_push(8'h55);
      check("slow_count", 32'(count), 32'd1);
      pop_chk();
      send_frame(8'h00, 1'b0, 192);
      repeat (10) @(posedge clk);
      #1;
      check("ferr_set", 32'(framing_err), 32'd1);
      check("ferr_count", 32'(count), 32'd0);
      pulse_clr();
      check("ferr_clr", 32'(framing_err), 32'd0);

      // overrun with five frames into four entries
      brgh = 1'b1;
      spbrg = 8'd0;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 16);
         sb_push(8'(i));
      end
      check("ovr_count", 32'(count), 32'd4);
      check("ovr_err", 32'(overrun_err), 32'd1);
      for (int i = 0; i < 4; i++) pop_chk();
      check("ovr_drained", 32'(count), 32'd0);
      pulse_clr();
      check("ovr_clr", 32'(overrun_err), 32'd0);

      // 3-clk glitch must not start a frame
      @(posedge clk); #1;
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rxd = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      check("glitch_count", 32'(count), 32'd0);
      check("glitch_ferr", 32'(framing_err), 32'd0);

      // push and pop together at full
      for (int i = 0; i < 4; i++) begin
         send_frame(8'h10 + 8'(i), 1'b1, 16);
         sb_push(8'h10 + 8'(i));
      end
      check("full_count", 32'(count), 32'd4);
      fork
         send_frame(8'h14, 1'b1, 16);
         begin
            @(negedge rxd);
            repeat (155) @(posedge clk);
            #1;
            check("simul_data", 32'(rd_data), 32'(exp_q.pop_front()));
            rd_en = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
            check("simul_count", 32'(count), 32'd4);
         end
      join
      exp_q.push_back(8'h14);
      check("simul_oerr", 32'(overrun_err), 32'd0);
      for (int i = 0; i < 4; i++) pop_chk();

      // abort mid-DATA with en low
      fork
         send_frame(8'h3C, 1'b1, 16);
         begin
            @(negedge rxd);
            repeat (64) @(posedge clk);
            #1;
            en = 1'b0;
         end
      join
      repeat (5) @(posedge clk);
      #1;
      en = 1'b1;
      check("abort_count", 32'(count), 32'd0);
      check("abort_ferr", 32'(framing_err), 32'd0);
      send_frame(8'hA5, 1'b1, 16);
      sb_push(8'hA5);
      check("a5_count", 32'(count), 32'd1);
      check("a5_data", 32'(rd_data), 32'(exp_q[0]));

      // asynchronous reset mid-frame
      fork
         send_frame(8'hFF, 1'b1, 16);
         begin
            @(negedge rxd);
            repeat (60) @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check("arst_count", 32'(count), 32'd0);
            check("arst_valid", 32'(rd_valid), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            exp_q.delete();
            check("rst2_data", 32'(rd_data), 32'd0);
         end
      join
      repeat (200) @(posedge clk);
      #1;
      check("rst2_count", 32'(count), 32'd0);
      check("rst2_errs", 32'({framing_err, overrun_err}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
